// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous pixel SRAM between the display-read
// port and the engine write port. Reads have priority; a saturating read
// streak counter forces a write through once MAX_RD_STREAK consecutive reads
// have been granted while a write was waiting. All SRAM strobes are
// registered from the next-state of the access FSM.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rd_req,
  input  logic [19:0] rd_addr,
  output logic        rd_ack,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  input  logic        wr_req,
  input  logic [19:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_be,
  output logic        wr_ack,
  output logic [19:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam int SW = ($clog2(MAX_RD_STREAK + 1) > 4) ? $clog2(MAX_RD_STREAK + 1) : 4;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_RD_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TURN} state_t;

  state_t        r_state;
  state_t        w_nstate;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_ncnt;
  logic [SW-1:0] r_streak;
  logic [1:0]    r_be;
  logic [1:0]    w_nbe;
  logic          w_dec;
  logic          w_wr_gnt;
  logic          w_rd_gnt;
  logic          w_capture;

  // Arbitration and next-state: decide in IDLE and on the last access cycle.
  always_comb begin
    w_dec     = (r_state == S_IDLE) ||
                (((r_state == S_RD) || (r_state == S_WR)) && (r_cnt == LAST));
    w_wr_gnt  = !reset && enable && w_dec && wr_req &&
                (!rd_req || (r_streak == SMAX));
    w_rd_gnt  = !reset && enable && w_dec && rd_req && !w_wr_gnt;
    w_capture = (r_state == S_RD) && (r_cnt == LAST);
    w_nbe     = w_wr_gnt ? wr_be : r_be;
    w_nstate  = r_state;
    w_ncnt    = r_cnt + 1'b1;
    if (w_wr_gnt) begin
      w_nstate = S_WR;
      w_ncnt   = '0;
    end else if (w_rd_gnt) begin
      // Only write-to-read needs a bus turnaround; read-to-write does not
      // because dq_oe only rises together with WR.
      w_nstate = (r_state == S_WR) ? S_TURN : S_RD;
      w_ncnt   = '0;
    end else if (w_dec) begin
      w_nstate = S_IDLE;
      w_ncnt   = '0;
    end else if (r_state == S_TURN) begin
      w_nstate = S_RD;
      w_ncnt   = '0;
    end
  end

  assign rd_ack = w_rd_gnt;
  assign wr_ack = w_wr_gnt;

  // Access FSM with Moore strobes registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      case (w_nstate)
        S_RD: begin
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= 1'b0;
          sram_we_n  <= 1'b1;
          sram_ub_n  <= 1'b0;
          sram_lb_n  <= 1'b0;
          sram_dq_oe <= 1'b0;
        end
        S_WR: begin
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= 1'b1;
          // Release we_n on the last cycle so data is held past its rising edge.
          sram_we_n  <= (w_ncnt == LAST);
          sram_ub_n  <= ~w_nbe[1];
          sram_lb_n  <= ~w_nbe[0];
          sram_dq_oe <= 1'b1;
        end
        default: begin
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

  // Read streak: counts reads granted while a write waits, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
    end else if (!wr_req || w_wr_gnt) begin
      r_streak <= '0;
    end else if (w_rd_gnt && (r_streak != SMAX)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  // Request latch: address and write data captured on the granting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else if (w_wr_gnt) begin
      sram_addr   <= wr_addr;
      sram_dq_out <= wr_data;
    end else if (w_rd_gnt) begin
      sram_addr   <= rd_addr;
    end
  end

  // Byte enables only matter while WR is active, so they carry no reset.
  always_ff @(posedge clk) begin
    r_be <= w_nbe;
  end

  // Read capture: sample the bus on the last RD cycle, flag it one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= w_capture;
      if (w_capture) begin
        rd_data <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: vector table for single grant decisions,
// directed multi-cycle sequences, and randomized traffic against a
// transaction-level memory/arbitration model with a behavioural SRAM.
module tb_sram_arbiter;

  localparam int N   = 2;
  localparam int MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rd_req;
  logic [19:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        wr_ack;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_in;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  int nchk = 0;
  int nerr = 0;

  sram_arbiter #(.ACCESS_CYCLES(N), .MAX_RD_STREAK(MAX)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ack(wr_ack),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'(32'h1100 + i * 515);
  endfunction

  // Behavioural 32-word SRAM with byte strobes.
  logic [15:0] mem [0:31];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= pat(i);
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_ub_n) mem[sram_addr[4:0]][15:8] <= sram_dq_out[15:8];
      if (!sram_lb_n) mem[sram_addr[4:0]][7:0]  <= sram_dq_out[7:0];
    end
  end
  assign sram_dq_in = mem[sram_addr[4:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    enable = 1'b1; rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = 2'b11;
  endtask

  // Leaves the bench at a negedge with reset low and the DUT in IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_init = 1'b1; clear_inputs();
    @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;
  endtask

  typedef struct packed {
    logic        en, rd, wr;
    logic [1:0]  be;
    logic [19:0] raddr, waddr;
    logic [15:0] wdata;
    logic        e_rack, e_wack, e_ce, e_oe, e_we, e_ub, e_lb, e_dqoe;
    logic [19:0] e_addr;
  } vec_t;

  vec_t vt [7];

  logic [15:0] refmem [0:31];
  logic [15:0] expq [$];
  logic [15:0] tmp16;
  int          ackc [4];
  int          valc [4];

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    // Reset state
    chk("rst_ce_n", 32'(sram_ce_n), 1);
    chk("rst_oe_n", 32'(sram_oe_n), 1);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_ub_lb", 32'({sram_ub_n, sram_lb_n}), 3);
    chk("rst_dq_oe", 32'(sram_dq_oe), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_dq_out", 32'(sram_dq_out), 0);
    chk("rst_acks", 32'({rd_ack, wr_ack, rd_valid}), 0);
    chk("rst_rd_data", 32'(rd_data), 0);

    // Vector table: one decision from IDLE, then the first access cycle.
    //           en    rd    wr    be     raddr      waddr      wdata     rk wk ce oe we ub lb oe  addr
    vt[0] = '{1'b0, 1'b1, 1'b1, 2'b11, 20'h00007, 20'h00009, 16'h5555, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 20'h00000};
    vt[1] = '{1'b1, 1'b1, 1'b0, 2'b11, 20'h12345, 20'h00000, 16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 20'h12345};
    vt[2] = '{1'b1, 1'b0, 1'b1, 2'b10, 20'h00000, 20'hABCDE, 16'h1234, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 20'hABCDE};
    vt[3] = '{1'b1, 1'b1, 1'b1, 2'b11, 20'h00400, 20'h00800, 16'h7777, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 20'h00400};
    vt[4] = '{1'b1, 1'b0, 1'b1, 2'b00, 20'h00000, 20'hFFFFF, 16'hFFFF, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1, 20'hFFFFF};
    vt[5] = '{1'b1, 1'b0, 1'b0, 2'b11, 20'h00003, 20'h00004, 16'h0101, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 20'h00000};
    vt[6] = '{1'b1, 1'b0, 1'b1, 2'b01, 20'h00000, 20'h00001, 16'h00FF, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 20'h00001};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      enable = vt[i].en; rd_req = vt[i].rd; wr_req = vt[i].wr; wr_be = vt[i].be;
      rd_addr = vt[i].raddr; wr_addr = vt[i].waddr; wr_data = vt[i].wdata;
      #1;
      chk($sformatf("vec%0d_rd_ack", i), 32'(rd_ack), 32'(vt[i].e_rack));
      chk($sformatf("vec%0d_wr_ack", i), 32'(wr_ack), 32'(vt[i].e_wack));
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
      #1;
      chk($sformatf("vec%0d_strobes", i),
          32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}),
          32'({vt[i].e_ce, vt[i].e_oe, vt[i].e_we, vt[i].e_ub, vt[i].e_lb, vt[i].e_dqoe}));
      chk($sformatf("vec%0d_addr", i), 32'(sram_addr), 32'(vt[i].e_addr));
      chk($sformatf("vec%0d_dq_out", i), 32'(sram_dq_out),
          32'(vt[i].e_wack ? vt[i].wdata : 16'h0000));
    end

    // Single read with its full latency.
    do_reset();
    rd_req = 1'b1; rd_addr = 20'h00010;
    #1; chk("single_rd_ack", 32'(rd_ack), 1);
    @(negedge clk); rd_req = 1'b0; #1;
    chk("single_t1_ce_oe", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b001);
    chk("single_t1_addr", 32'(sram_addr), 32'h10);
    chk("single_t1_valid", 32'(rd_valid), 0);
    @(negedge clk); #1;
    chk("single_t2_ce_oe", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b001);
    chk("single_t2_valid", 32'(rd_valid), 0);
    @(negedge clk); #1;
    chk("single_t3_valid", 32'(rd_valid), 1);
    chk("single_t3_data", 32'(rd_data), 32'hBEEF);
    chk("single_t3_ce", 32'(sram_ce_n), 1);
    @(negedge clk); #1;
    chk("single_t4_valid", 32'(rd_valid), 0);
    chk("single_t4_hold", 32'(rd_data), 32'hBEEF);

    // Four back-to-back reads.
    begin
      int nack, nval;
      nack = 0; nval = 0;
      do_reset();
      for (int c = 0; c < 14; c++) begin
        if (c > 0) @(negedge clk);
        rd_req = (nack < 4); rd_addr = 20'(nack);
        #1;
        if (rd_ack && nack < 4) begin ackc[nack] = c; nack++; end
        if (rd_valid && nval < 4) begin
          valc[nval] = c;
          chk($sformatf("b2b_data%0d", nval), 32'(rd_data), 32'(pat(nval)));
          nval++;
        end
      end
      chk("b2b_nack", nack, 4);
      chk("b2b_nval", nval, 4);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("b2b_ack_cyc%0d", i), ackc[i], 2 * i);
        chk($sformatf("b2b_val_cyc%0d", i), valc[i], 2 * i + 3);
      end
    end

    // Write held against continuous reads: exactly MAX reads, then the write.
    begin
      int  nrd;
      bit  got_w, resumed, after;
      nrd = 0; got_w = 0; resumed = 0; after = 0;
      do_reset();
      wr_req = 1'b1; wr_addr = 20'h3; wr_data = 16'hCAFE; wr_be = 2'b11;
      rd_req = 1'b1; rd_addr = 20'h2;
      for (int c = 0; c < 60; c++) begin
        if (c > 0) @(negedge clk);
        if (got_w) wr_req = 1'b0;
        #1;
        if (got_w && !after && (rd_ack || wr_ack)) begin
          after = 1; resumed = rd_ack;
        end
        if (rd_ack && !got_w) nrd++;
        if (wr_ack) got_w = 1;
      end
      chk("streak_reads", nrd, MAX);
      chk("streak_write", 32'(got_w), 1);
      chk("streak_resume", 32'(resumed), 1);
    end

    // Partial write followed by a read of the same word through TURN.
    do_reset();
    wr_req = 1'b1; wr_addr = 20'h5; wr_data = 16'h1234; wr_be = 2'b10;
    #1; chk("wr_ack", 32'(wr_ack), 1);
    @(negedge clk); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 20'h5; #1;
    chk("wr_t1_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 32'b010011);
    chk("wr_t1_dq", 32'(sram_dq_out), 32'h1234);
    chk("wr_t1_no_rack", 32'(rd_ack), 0);
    @(negedge clk); #1;
    chk("wr_t2_we_oe", 32'({sram_we_n, sram_dq_oe}), 32'b11);
    chk("wr_t2_rack", 32'(rd_ack), 1);
    @(negedge clk); rd_req = 1'b0; #1;
    chk("turn_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b1110);
    @(negedge clk); #1;
    chk("turn_then_rd", 32'({sram_ce_n, sram_oe_n, sram_dq_oe}), 32'b000);
    @(negedge clk);
    @(negedge clk); #1;
    tmp16 = pat(5);
    chk("wr_rd_valid", 32'(rd_valid), 1);
    chk("wr_rd_data", 32'(rd_data), 32'({8'h12, tmp16[7:0]}));

    // Reset on the first RD cycle abandons the read.
    do_reset();
    rd_req = 1'b1; rd_addr = 20'h3;
    #1; chk("rstmid_ack", 32'(rd_ack), 1);
    @(negedge clk); rd_req = 1'b0; reset = 1'b1; #1;
    chk("rstmid_in_rd", 32'(sram_ce_n), 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("rstmid_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 32'b111110);
    chk("rstmid_valid0", 32'(rd_valid), 0);
    @(negedge clk); #1; chk("rstmid_valid1", 32'(rd_valid), 0);
    @(negedge clk); #1; chk("rstmid_valid2", 32'(rd_valid), 0);
    rd_req = 1'b1; #1; chk("rstmid_idle_grant", 32'(rd_ack), 1);
    @(negedge clk); rd_req = 1'b0;

    // enable low blocks grants; reader wins once it rises.
    do_reset();
    enable = 1'b0; rd_req = 1'b1; wr_req = 1'b1; rd_addr = 20'h8; wr_addr = 20'h9;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1; chk($sformatf("en0_acks%0d", c), 32'({rd_ack, wr_ack}), 0);
    end
    @(negedge clk); enable = 1'b1; #1;
    chk("en1_acks", 32'({rd_ack, wr_ack}), 32'b10);

    // Randomized traffic against a transaction-level model.
    begin
      int  streak_m, rd_wait, wr_wait;
      bit  seen_r, seen_w, ok;
      do_reset();
      for (int i = 0; i < 32; i++) refmem[i] = pat(i);
      expq.delete();
      streak_m = 0; rd_wait = 0; wr_wait = 0; seen_r = 0; seen_w = 0;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        if (seen_r) rd_req = 1'b0;
        if (!rd_req && $urandom_range(0, 3) != 0) begin
          rd_req = 1'b1; rd_addr = 20'($urandom_range(0, 31));
        end
        if (seen_w) wr_req = 1'b0;
        if (!wr_req && $urandom_range(0, 3) == 0) begin
          wr_req = 1'b1; wr_addr = 20'($urandom_range(0, 31));
          wr_data = 16'($urandom); wr_be = 2'($urandom_range(0, 3));
        end
        enable = ($urandom_range(0, 7) != 0);
        #1;
        if (rd_ack) begin
          ok = rd_req && enable && !wr_ack && !(wr_req && streak_m >= MAX);
          chk("rand_rd_grant_ok", 32'(ok), 1);
          expq.push_back(refmem[rd_addr[4:0]]);
          if (wr_req && streak_m < MAX) streak_m++;
        end
        if (wr_ack) begin
          ok = wr_req && enable && !(rd_req && streak_m < MAX);
          chk("rand_wr_grant_ok", 32'(ok), 1);
          if (wr_be[1]) refmem[wr_addr[4:0]][15:8] = wr_data[15:8];
          if (wr_be[0]) refmem[wr_addr[4:0]][7:0]  = wr_data[7:0];
          streak_m = 0;
        end
        if (!wr_req) streak_m = 0;
        if (rd_valid) begin
          chk("rand_valid_expected", 32'(expq.size() != 0), 1);
          if (expq.size() != 0) chk("rand_rd_data", 32'(rd_data), 32'(expq.pop_front()));
        end
        rd_wait = (rd_req && !rd_ack) ? rd_wait + 1 : 0;
        wr_wait = (wr_req && !wr_ack) ? wr_wait + 1 : 0;
        if (rd_wait > 200) begin chk("rand_rd_starved", rd_wait, 0); rd_wait = 0; end
        if (wr_wait > 200) begin chk("rand_wr_starved", wr_wait, 0); wr_wait = 0; end
        seen_r = rd_ack; seen_w = wr_ack;
      end
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0; enable = 1'b1;
        #1;
        if (rd_valid) begin
          chk("drain_valid_expected", 32'(expq.size() != 0), 1);
          if (expq.size() != 0) chk("drain_rd_data", 32'(rd_data), 32'(expq.pop_front()));
        end
      end
      chk("rand_all_reads_returned", expq.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
